// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

   // Width of the big-endian word-count header.
   localparam int unsigned HDR_W = 16;

   typedef enum logic [2:0] {
      StHdrHi,
      StHdrLo,
      StChkLen,
      StData,
      StCksum,
      StDone,
      StError
   } boot_state_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_CKSUM   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   // States in which an idle input counts toward the transfer timeout.
   function automatic logic timeout_armed(boot_state_e s);
      return (s == StHdrLo) || (s == StData) || (s == StCksum);
   endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs four consecutive bytes, MSB first, into a 32-bit word and pulses
// word_valid for one cycle after the fourth byte.
module byte_word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [1:0]  byte_idx,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  idx_q;
   logic [31:0] shift_q;
   logic        valid_q;

   // Shift accepted bytes in and flag the cycle after a word completes.
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         idx_q   <= 2'd0;
         shift_q <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= byte_en && (idx_q == 2'd3);
         if (byte_en) begin
            shift_q <= {shift_q[23:0], byte_in};
            idx_q   <= idx_q + 2'd1;
         end
      end
   end

   assign byte_idx   = idx_q;
   assign word       = shift_q;
   assign word_valid = valid_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a framed program image over a byte stream, writes it into
// instruction memory and releases the CPU only after the checksum matches.
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              restart,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int unsigned IdleW    = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned MaxWords = 1 << ADDR_W;
   localparam logic [ADDR_W:0] WlOne = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [IdleW-1:0] IdleOne = {{(IdleW-1){1'b0}}, 1'b1};
   localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYC - 1);

   boot_state_e       state_q;
   logic [HDR_W-1:0]  len_q;
   logic [7:0]        acc_q;
   logic [IdleW-1:0]  idle_q;
   logic [ADDR_W:0]   words_loaded_q;
   logic              in_ready_q;
   logic              cpu_reset_q;
   logic              done_q;
   logic              error_q;
   logic [1:0]        err_code_q;

   logic        accept;
   logic        restart_ok;
   logic        pk_byte_en;
   logic [1:0]  pk_idx;
   logic [31:0] pk_word;
   logic        pk_valid;
   logic        idle_tick;

   assign accept     = in_valid && in_ready_q;
   assign restart_ok = restart && ((state_q == StDone) || (state_q == StError));
   assign pk_byte_en = accept && (state_q == StData);
   assign idle_tick  = timeout_armed(state_q) && !in_valid;

   byte_word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (restart_ok),
      .byte_en    (pk_byte_en),
      .byte_in    (in_data),
      .byte_idx   (pk_idx),
      .word       (pk_word),
      .word_valid (pk_valid)
   );

   // Frame-parsing FSM with checksum, idle timer, word counter and status flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= StHdrHi;
         len_q          <= '0;
         acc_q          <= 8'd0;
         idle_q         <= '0;
         words_loaded_q <= '0;
         in_ready_q     <= 1'b1;
         cpu_reset_q    <= 1'b1;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
         err_code_q     <= ERR_NONE;
      end else begin
         if (accept) begin
            idle_q <= '0;
         end else if (idle_tick) begin
            idle_q <= idle_q + IdleOne;
         end

         if (pk_valid) begin
            words_loaded_q <= words_loaded_q + WlOne;
         end

         // The checksum byte itself is not part of the XOR.
         if (accept && (state_q != StCksum)) begin
            acc_q <= acc_q ^ in_data;
         end

         unique case (state_q)
            StHdrHi: begin
               if (accept) begin
                  len_q[15:8] <= in_data;
                  state_q     <= StHdrLo;
               end
            end
            StHdrLo: begin
               if (accept) begin
                  len_q[7:0] <= in_data;
                  state_q    <= StChkLen;
                  in_ready_q <= 1'b0;
               end
            end
            StChkLen: begin
               in_ready_q <= 1'b1;
               if (32'(len_q) > MaxWords) begin
                  state_q    <= StError;
                  in_ready_q <= 1'b0;
                  error_q    <= 1'b1;
                  err_code_q <= ERR_LEN;
               end else if (len_q == '0) begin
                  state_q <= StCksum;
               end else begin
                  state_q <= StData;
               end
            end
            StData: begin
               // Word being completed has index words_loaded: the previous
               // write has always retired before the next fourth byte.
               if (pk_byte_en && (pk_idx == 2'd3) &&
                   (32'(words_loaded_q) + 32'd1 == 32'(len_q))) begin
                  state_q <= StCksum;
               end
            end
            StCksum: begin
               if (accept) begin
                  in_ready_q <= 1'b0;
                  if (in_data == acc_q) begin
                     state_q     <= StDone;
                     done_q      <= 1'b1;
                     cpu_reset_q <= 1'b0;
                  end else begin
                     state_q    <= StError;
                     error_q    <= 1'b1;
                     err_code_q <= ERR_CKSUM;
                  end
               end
            end
            StDone, StError: begin
               in_ready_q <= 1'b0;
            end
            default: begin
               state_q    <= StError;
               in_ready_q <= 1'b0;
            end
         endcase

         if (idle_tick && (idle_q == IdleLast)) begin
            state_q    <= StError;
            in_ready_q <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
         end

         if (restart_ok) begin
            state_q        <= StHdrHi;
            acc_q          <= 8'd0;
            idle_q         <= '0;
            words_loaded_q <= '0;
            in_ready_q     <= 1'b1;
            cpu_reset_q    <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            err_code_q     <= ERR_NONE;
         end
      end
   end

   assign in_ready     = in_ready_q;
   assign imem_we      = pk_valid;
   assign imem_addr    = words_loaded_q[ADDR_W-1:0];
   assign imem_wdata   = pk_word;
   assign cpu_reset    = cpu_reset_q;
   assign done         = done_q;
   assign error        = error_q;
   assign err_code     = err_code_q;
   assign words_loaded = words_loaded_q;

endmodule
